// File: rtl/memory_be.sv
// memory_be: parametrised single-port synchronous RAM with per-byte write
// enables, a registered read port and a hardware clear sequencer that zeroes
// the array after reset release or on a clr request.
module memory_be #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 5,
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [NB-1:0]         be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic [DATA_WIDTH-1:0]   dout_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [NB-1:0]           mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Select the single write port owner: the clear sequencer or the user.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_we    = '0;
    mem_waddr = clr_addr_q;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we = '1;
    end else if (!clr && cen && wen) begin
      mem_we    = be;
      mem_waddr = addr;
      mem_wdata = din;
    end
    // Reset alone must never modify the array, even with the clock running.
    if (!reset_n) begin
      mem_we = '0;
    end
  end

  // Storage array with byte-lane write enables.
  // NOTE: the array has no reset; it is zeroed by the clear sequencer instead,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_we[k]) begin
        mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // Clear sequencer state, clear address counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples pre-edge values regardless of block order.
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      dout_q     <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          dout_q     <= '0;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (clr) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            dout_q     <= '0;
          end else if (cen && !wen) begin
            dout_q <= mem[addr];
          end else begin
            dout_q <= '0;
          end
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_memory_be.sv
// Self-checking bench for memory_be at default parameters (32x32, 4 lanes).
// A plain array model tracks the expected memory contents.
module tb_memory_be;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [4:0]  addr = '0;
  logic [31:0] din = '0;
  logic        clr = 1'b0;
  logic [31:0] dout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [32];

  memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cen    (cen),
    .wen    (wen),
    .be     (be),
    .addr   (addr),
    .din    (din),
    .clr    (clr),
    .dout   (dout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One user access through the model; dout is checked after the edge.
  task automatic access(input string tag, input bit c, input bit w, input logic [3:0] b,
                        input logic [4:0] a, input logic [31:0] d);
    logic [31:0] exp;
    cen = c; wen = w; be = b; addr = a; din = d;
    exp = (c && !w) ? mdl[a] : 32'h0;
    if (c && w) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
      end
    end
    step();
    check(tag, dout, exp);
  endtask

  // Count edges until busy falls, bounded; n_start counts edges already seen.
  task automatic wait_clear(input string tag, input int n_start, input int expected);
    int n;
    n = n_start;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check(tag, n, expected);
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) access(tag, 1'b1, 1'b0, 4'h0, 5'(i), 32'h0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset state.
    step();
    step();
    check("rst_dout", dout, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);

    // Reset release: exactly 32 edges of busy, then all zero.
    #2 reset_n = 1'b1;
    wait_clear("rel_edges", 0, 32);
    read_all("init_zero");

    // Full write, then read back.
    access("wr_full_dout", 1'b1, 1'b1, 4'hF, 5'd3, 32'hDEADBEEF);
    access("rd_full", 1'b1, 1'b0, 4'h0, 5'd3, 32'h0);
    check("rd_full_lit", dout, 32'hDEADBEEF);

    // Byte mask.
    access("wr_mask_dout", 1'b1, 1'b1, 4'b0101, 5'd3, 32'h11223344);
    access("rd_mask", 1'b1, 1'b0, 4'h0, 5'd3, 32'h0);
    check("rd_mask_lit", dout, 32'hDE22BE44);
    access("wr_be0_dout", 1'b1, 1'b1, 4'b0000, 5'd3, 32'hFFFFFFFF);
    access("rd_be0", 1'b1, 1'b0, 4'h0, 5'd3, 32'h0);
    check("rd_be0_lit", dout, 32'hDE22BE44);

    // Disabled access.
    access("rd_pre_cen0", 1'b1, 1'b0, 4'h0, 5'd3, 32'h0);
    access("cen0", 1'b0, 1'b0, 4'h0, 5'd3, 32'h0);

    // Fill, then clr pulse: busy for 33 edges; writes during busy are dropped.
    for (int i = 0; i < 32; i++) access("fill", 1'b1, 1'b1, 4'hF, 5'(i), 32'hFFFFFFFF);
    cen = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", {31'h0, busy}, 32'h1);
    check("clr_dout", dout, 32'h0);
    cen = 1'b1; wen = 1'b1; be = 4'hF; addr = 5'd7; din = 32'hA5A5A5A5;
    n = 1;
    while (busy && n < 100) begin
      step();
      n++;
      if (n == 5) check("busy_dout", dout, 32'h0);
    end
    check("clr_edges", n, 33);
    cen = 1'b0; wen = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    read_all("after_clr");

    // clr has priority over a simultaneous write.
    access("pre5", 1'b1, 1'b1, 4'hF, 5'd5, 32'h12345678);
    clr = 1'b1; cen = 1'b1; wen = 1'b1; be = 4'hF; addr = 5'd5; din = 32'hCAFEBABE;
    step();
    clr = 1'b0; cen = 1'b0; wen = 1'b0;
    wait_clear("clr_wr_edges", 1, 33);
    access("clr_wr_rd5", 1'b1, 1'b0, 4'h0, 5'd5, 32'h0);
    check("clr_wr_rd5_lit", dout, 32'h0);

    // Randomised accesses against the model.
    for (int i = 0; i < 400; i++) begin
      access("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
             5'($urandom), $urandom);
    end

    // Asynchronous reset from IDLE with nonzero dout.
    access("wr9", 1'b1, 1'b1, 4'hF, 5'd9, 32'h0BADF00D);
    access("rd9", 1'b1, 1'b0, 4'h0, 5'd9, 32'h0);
    cen = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("arst_dout", dout, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h1);
    #1 reset_n = 1'b1;
    wait_clear("arst_edges", 0, 32);
    read_all("arst_zero");

    // Reset during a clear at edge 10: sequence restarts from address 0.
    for (int i = 0; i < 32; i++) access("fill2", 1'b1, 1'b1, 4'hF, 5'(i), 32'hFFFFFFFF);
    cen = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #1 reset_n = 1'b0;
    #1;
    check("mid_dout", dout, 32'h0);
    check("mid_busy", {31'h0, busy}, 32'h1);
    #1 reset_n = 1'b1;
    wait_clear("mid_edges", 0, 32);
    read_all("mid_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_be.md
# memory_be

Parametrised single-port synchronous RAM with per-byte write enables and a built-in clear sequencer. It is the next generation of the team's 32x32 memory block: width and depth are parameters, writes can be masked per byte, and the array is zeroed by hardware after reset or on request. Because the array is zeroed in hardware, simulation-only initialisation is no longer needed. The block sits behind any datapath stage that needs scratch or register-file storage with a one-cycle read.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH words
- NB (derived, not overridable), DATA_WIDTH/8, number of byte lanes

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- cen  in  1  chip enable; access only when 1
- wen  in  1  1 = write, 0 = read (qualified by cen)
- be  in  NB  byte write enables; be[k] covers din[8k+7:8k]
- addr  in  ADDR_WIDTH  word address
- din  in  DATA_WIDTH  write data
- clr  in  1  single-cycle request to zero the whole array
- dout  out  DATA_WIDTH  registered read data
- busy  out  1  1 while the clear sequencer owns the array

## Operation
- State machine with two states:
  - CLEAR: a counter clr_addr (ADDR_WIDTH bits) writes 0 to mem[clr_addr] every edge.
    - Counter increments each edge; at clr_addr == DEPTH-1, write the last word, next state IDLE.
    - busy = 1, dout held 0.
    - cen, wen, be, addr, din and clr are all ignored.
  - IDLE: busy = 0; user access decoded in priority order:
    - clr = 1: next state CLEAR, clr_addr <= 0, dout <= 0. Any cen access in the same cycle is dropped.
    - cen & wen: for each k with be[k] = 1, mem[addr] byte k <= din byte k; other bytes unchanged; dout <= 0.
    - cen & !wen: dout <= mem[addr].
    - !cen: dout <= 0.
- Write with be = 0: array unchanged, dout <= 0.
- Reset (reset_n = 0), effective immediately and asynchronously:
  - dout = 0, busy = 1, state = CLEAR, clr_addr = 0.
  - Array contents are not touched by reset itself; the clear sequencer zeroes them after release.
- Reset asserted mid-clear: the sequence restarts from address 0 on release.
- Address is always in range (power-of-two depth); no wrap logic.

## Timing
- Read latency is one cycle: addr sampled on edge N, data on dout after edge N, valid through edge N+1.
- Write then read of the same address on consecutive edges returns the newly written value; no extra hazard cycle.
- dout changes only on clock edges, or asynchronously to 0 on reset.
- After reset release: busy stays 1 for DEPTH rising edges and is 0 after the DEPTH-th edge. The first user access is accepted on the next edge.
- clr accepted in IDLE: busy rises after that edge and stays 1 for DEPTH further edges, i.e. DEPTH+1 edges of busy in total.
- clr while busy has no effect; it neither restarts nor extends the sequence.
- No handshake on user accesses; users must hold off while busy = 1. Accesses during busy are silently discarded.

## Test plan
Defaults DATA_WIDTH = 32, ADDR_WIDTH = 5.
- Reset release:
  - Count edges until busy falls: exactly 32.
  - Then read addresses 0..31: every dout = 0x00000000.
- Full write then read:
  - Write addr 3, din 0xDEADBEEF, be 4'b1111 -> dout = 0 after the write edge.
  - Read addr 3 on the next edge -> dout = 0xDEADBEEF.
- Byte mask:
  - Write addr 3, din 0x11223344, be 4'b0101.
  - Read addr 3 -> 0xDE22BE44.
  - Write with be 4'b0000 -> value unchanged.
- Disabled and blocked accesses:
  - cen = 0 for one edge -> dout = 0.
  - Write 0xA5A5A5A5 to addr 7 while busy = 1 -> after busy falls, read addr 7 = 0.
- clr pulse and priority:
  - Fill addrs 0..31 with 0xFFFFFFFF, pulse clr -> busy high for 33 edges.
  - Afterwards all reads return 0.
  - clr together with a write to addr 5 -> addr 5 reads 0.
- Reset mid-clear:
  - Assert reset_n = 0 at clear edge 10 -> dout = 0 and busy = 1 immediately, no clock required.
  - On release -> a full 32-edge clear.
